// File: rtl/prog_mem_controller.sv
// prog_mem_controller
//   Round-robin arbiter placing instruction-fetch requests from NUM_CONSUMERS
//   fetchers onto one program-memory read channel, one read outstanding at a
//   time. Each completed read is returned to its fetcher with a one-cycle ack.
//
// Ports
//   clk, rst             clock (posedge) and synchronous active-high reset
//   consumer_read_valid  per-fetcher request
//   consumer_read_addr   packed request addresses, fetcher i at [i*ADDR_BITS +: ADDR_BITS]
//   consumer_read_ack    per-fetcher one-cycle completion pulse
//   consumer_read_data   packed returned instructions, same packing as addresses
//   mem_read_valid/addr  read request to program memory
//   mem_read_ready/data  memory response (data valid while ready is high)
//   mem_error            sticky timeout flag (only with PROG_MEM_CTRL_TIMEOUT_EN)
//
// Build option
//   PROG_MEM_CTRL_TIMEOUT_EN: abandon a read after TIMEOUT_CYCLES waiting
//   cycles, return a NOP (all zeros) and raise mem_error.
module prog_mem_controller #(
  parameter int unsigned NUM_CONSUMERS  = 4,
  parameter int unsigned ADDR_BITS      = 6,
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ack,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_addr,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
`ifdef PROG_MEM_CTRL_TIMEOUT_EN
  ,
  output logic                               mem_error
`endif
);

  localparam int unsigned GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ_WAITING = 2'd1,
    RELAYING     = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [GW-1:0]            grant;
  logic [GW-1:0]            last_grant;
  logic [NUM_CONSUMERS-1:0] lockout;

  logic [NUM_CONSUMERS-1:0] eligible;
  logic                     pick_found;
  logic [GW-1:0]            pick_idx;
  logic [ADDR_BITS-1:0]     pick_addr;
  logic [NUM_CONSUMERS-1:0] grant_onehot;
  logic                     timeout_hit;
  logic                     mem_done;
  logic [DATA_BITS-1:0]     ret_data;
  int unsigned              cand;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (pick_found) state_next = READ_WAITING;
      READ_WAITING: if (mem_done)   state_next = RELAYING;
      RELAYING:                     state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Arbitration and completion decode
  always_comb begin
    eligible   = consumer_read_valid & ~lockout;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    // Priority rotates: search starts one past the last consumer served.
    for (int unsigned k = 1; k <= NUM_CONSUMERS; k++) begin
      cand = (32'(last_grant) + k) % NUM_CONSUMERS;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
        if (!pick_found && cand == i && eligible[i]) begin
          pick_found = 1'b1;
          pick_idx   = GW'(i);
        end
      end
    end

    pick_addr = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (pick_idx == GW'(i)) pick_addr = consumer_read_addr[i*ADDR_BITS +: ADDR_BITS];
    end

    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      grant_onehot[i] = (grant == GW'(i));
    end

    mem_done = (state == READ_WAITING) && (mem_read_ready || timeout_hit);
    // A timed-out read returns all zeros (NOP); ready always wins.
    ret_data = mem_read_ready ? mem_read_data : '0;
  end

  // Registered outputs and arbitration bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_valid     <= 1'b0;
      mem_read_addr      <= '0;
      consumer_read_ack  <= '0;
      consumer_read_data <= '0;
      grant              <= '0;
      last_grant         <= GW'(NUM_CONSUMERS - 1);
      lockout            <= '0;
    end else begin
      // A served fetcher stays locked out until it drops its request.
      lockout <= (lockout & consumer_read_valid) | (mem_done ? grant_onehot : '0);
      case (state)
        IDLE: begin
          if (pick_found) begin
            mem_read_valid <= 1'b1;
            mem_read_addr  <= pick_addr;
            grant          <= pick_idx;
            last_grant     <= pick_idx;
          end
        end
        READ_WAITING: begin
          if (mem_done) begin
            mem_read_valid    <= 1'b0;
            mem_read_addr     <= '0;
            consumer_read_ack <= grant_onehot;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
              if (grant_onehot[i]) consumer_read_data[i*DATA_BITS +: DATA_BITS] <= ret_data;
            end
          end
        end
        RELAYING: consumer_read_ack <= '0;
        default:  consumer_read_ack <= '0;
      endcase
    end
  end

`ifdef PROG_MEM_CTRL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  // wait_cnt holds the number of ready-less cycles already spent waiting,
  // so the limit is hit on the TIMEOUT_CYCLES-th such cycle.
  assign timeout_hit = (state == READ_WAITING) && !mem_read_ready &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      if (state != READ_WAITING)  wait_cnt <= '0;
      else if (!mem_read_ready)   wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) mem_error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/prog_mem_controller.md
Name: prog_mem_controller

Overview:
- Arbitrates instruction-fetch requests from NUM_CONSUMERS fetchers onto a single program-memory read channel.
- Sits directly upstream of each fetcher. The per-consumer read_valid / read_addr / read_ack / read_data ports are the fetcher's prog_mem_read_* signals.
- Round-robin grant; one outstanding memory read at a time.
- Returns each instruction to the requesting fetcher with a one-cycle ack pulse.

Parameters:
- NUM_CONSUMERS, 4, number of fetchers served.
- ADDR_BITS, 6, program memory address width.
- DATA_BITS, 32, instruction width.
- TIMEOUT_CYCLES, 255, memory wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request.
- consumer_read_addr  in  NUM_CONSUMERS*ADDR_BITS  packed addresses; consumer i at [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ack  out  NUM_CONSUMERS  per-fetcher one-cycle completion pulse.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed instruction data, same packing as addresses.
- mem_read_valid  out  1  read request to program memory.
- mem_read_addr  out  ADDR_BITS  address to program memory.
- mem_read_ready  in  1  memory has data on mem_read_data this cycle.
- mem_read_data  in  DATA_BITS  instruction from memory.
- mem_error  out  1  sticky timeout flag; exists only when PROG_MEM_CTRL_TIMEOUT_EN is defined.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = NUM_CONSUMERS-1 (consumer 0 has first priority), lockout mask 0.
  - rst mid-transaction aborts it: mem_read_valid drops next edge and no ack is issued.
- State encoding: IDLE=0, READ_WAITING=1, RELAYING=2.
- IDLE:
  - Eligible request set = consumer_read_valid & ~lockout.
  - If non-empty, grant the first eligible consumer searching from (last_grant+1) mod NUM_CONSUMERS upward with wrap-around.
  - On grant: mem_read_valid<=1, mem_read_addr<=granted address, grant index and last_grant <= granted index, state<=READ_WAITING.
- READ_WAITING:
  - mem_read_valid stays 1 and mem_read_addr stays stable until mem_read_ready.
  - On mem_read_ready=1: mem_read_valid<=0, mem_read_addr<=0, consumer_read_data[grant]<=mem_read_data, consumer_read_ack[grant]<=1, lockout[grant]<=1, state<=RELAYING.
- RELAYING: consumer_read_ack<=0, state<=IDLE.
  - consumer_read_data[grant] holds its value until that consumer's next completion.
- Lockout:
  - lockout[i] clears on any edge where consumer_read_valid[i]=0.
  - A fetcher must drop read_valid before it can be served again, so a request left high after ack is never re-served.
- Latency: request seen in IDLE at edge E gives mem_read_valid high after E. Ready sampled at edge E+k (k>=1) gives ack high for exactly one cycle after E+k. Minimum request-to-ack is 2 edges.
- Simultaneous requests: exactly one grant per transaction. Others wait, with their valid held high.
- Valid dropped while waiting to be granted: the request is withdrawn, no side effects.
- Valid dropped while granted: the transaction still completes and acks.
- At most one bit of consumer_read_ack is high in any cycle.

Optional Feature:
- Macro: PROG_MEM_CTRL_TIMEOUT_EN.
- When defined:
  - A wait counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to READ_WAITING and increments each READ_WAITING cycle without ready.
  - On reaching TIMEOUT_CYCLES with no ready: mem_read_valid<=0, consumer_read_data[grant]<=0 (NOP), ack pulses as normal, mem_error<=1 (sticky until rst), state<=RELAYING.
  - If mem_read_ready=1 in the same cycle the limit is reached, ready wins: real data returned, no error.
- When undefined: no counter, no mem_error port, and READ_WAITING waits indefinitely.

Test Plan:
- Single request: consumer 0 valid, addr 6'h05; memory ready 3 cycles later with 32'hDEADBEEF -> mem_read_addr=5 while waiting; ack[0] one cycle; data0=DEADBEEF; no second read while valid stays high.
- All four request at once (addrs 1,2,3,4), memory ready 1 cycle after each valid -> grant order 0,1,2,3; each ack carries its own data; one ack high per cycle max.
- Fairness: consumers 1 and 3 re-request right after drop-and-reassert -> after 3 is served, 1 is granted before 3 again (wrap-around via 0).
- Reset mid-operation: rst in READ_WAITING -> next cycle mem_read_valid=0, no ack, consumer 0 granted first after release.
- Withdrawal: consumer 2 raises then drops valid while consumer 1 is being served -> consumer 2 never granted, no ack[2].
- Timeout (macro on, TIMEOUT_CYCLES=8): memory never ready -> after 8 waiting cycles ack pulses with data 0 and mem_error=1 stays high; macro off -> still waiting at cycle 100.
